// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared types and limits for the toggle-handshake CDC blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package cdc_pkg;

  // Source-side handshake state
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_state_e;

  // Legal depth range for the synchronizer chains
  localparam int CDC_SYNC_MIN = 2;
  localparam int CDC_SYNC_MAX = 4;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/sync_ff_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff_chain
//  Description : 1-bit multi-flop synchronizer with asynchronous active-low
//                clear. Shared by both ends of the toggle handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ff_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic ck,
  input  logic cdn,
  input  logic async_i,
  output logic sync_o
);

  if ((STAGES < CDC_SYNC_MIN) || (STAGES > CDC_SYNC_MAX)) begin : g_bad_stages
    $error("sync_ff_chain: STAGES out of range");
  end

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous input through the flop chain, oldest sample at the top
  always_ff @(posedge ck or negedge cdn) begin
    if (!cdn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule : sync_ff_chain
`default_nettype wire

// File: rtl/cdc_toggle_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_toggle_tx
//  Description : Sending end of a two-phase toggle CDC handshake. Captures a
//                word onto a stable crossing bus, flips req_tgl, and reopens
//                once the synchronized ack toggle matches req_tgl again.
//                Optional watchdog enabled by macro CDC_TOGGLE_TX_TIMEOUT_EN
//                (adds err_clr input and sticky err output).
//  Revision    : 1.0  initial release
// ============================================================================
module cdc_toggle_tx
  import cdc_pkg::*;
#(
  parameter int DW             = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          ck,
  input  logic          cdn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] xd_data,
  output logic          req_tgl,
  input  logic          ack_tgl_async,
  output logic          done,
  output logic          busy
`ifdef CDC_TOGGLE_TX_TIMEOUT_EN
  ,
  input  logic          err_clr,
  output logic          err
`endif
);

  if ((DW < 1) || (DW > 64)) begin : g_bad_dw
    $error("cdc_toggle_tx: DW out of range");
  end
  if ((SYNC_STAGES < CDC_SYNC_MIN) || (SYNC_STAGES > CDC_SYNC_MAX)) begin : g_bad_sync
    $error("cdc_toggle_tx: SYNC_STAGES out of range");
  end
  if (TIMEOUT_CYCLES < 16) begin : g_bad_timeout
    $error("cdc_toggle_tx: TIMEOUT_CYCLES must be >= 16");
  end

  cdc_state_e    state_q, state_d;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          ack_s;
  logic          levels_match;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .ck      (ck),
    .cdn     (cdn),
    .async_i (ack_tgl_async),
    .sync_o  (ack_s)
  );

  // Handshake is closed when the returned ack level equals our request level
  assign levels_match = (ack_s == req_q);
  assign in_ready     = (state_q == IDLE) && levels_match;
  assign busy         = (state_q == WAIT_ACK);
  assign xd_data      = data_q;
  assign req_tgl      = req_q;
  assign done         = done_q;

  // Next-state logic: capture and toggle from IDLE, close out on matching ack
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (levels_match) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake registers; data and request flip on the same edge
  always_ff @(posedge ck or negedge cdn) begin
    if (!cdn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

`ifdef CDC_TOGGLE_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout_hit;

  // The count reaches TIMEOUT_CYCLES on the edge ending that many WAIT_ACK cycles
  assign timeout_hit = (state_q == WAIT_ACK) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;

  // Watchdog: restart on each capture, count while waiting, saturate; timeout beats clear
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q == IDLE) && (state_d == WAIT_ACK)) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_ACK) && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Watchdog registers
  always_ff @(posedge ck or negedge cdn) begin
    if (!cdn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule : cdc_toggle_tx
`default_nettype wire

// File: tb/tb_cdc_toggle_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_toggle_tx
//  Description : Self-checking bench for cdc_toggle_tx (DW=8, SYNC_STAGES=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdc_toggle_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          ck = 1'b0;
  logic          cdn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] xd_data;
  logic          req_tgl;
  logic          ack_tgl_async;
  logic          done;
  logic          busy;
`ifdef CDC_TOGGLE_TX_TIMEOUT_EN
  logic          err_clr;
  logic          err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cdc_toggle_tx #(
    .DW             (DW),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ck            (ck),
    .cdn           (cdn),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .xd_data       (xd_data),
    .req_tgl       (req_tgl),
    .ack_tgl_async (ack_tgl_async),
    .done          (done),
    .busy          (busy)
`ifdef CDC_TOGGLE_TX_TIMEOUT_EN
    ,
    .err_clr       (err_clr),
    .err           (err)
`endif
  );

  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ack;
    logic          rdy;
    logic          req;
    logic [DW-1:0] xd;
    logic          bsy;
    logic          dn;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [DW-1:0] words [3];
    logic [2:0]    dly;
    logic          prev_req, exp_req;
    logic [DW-1:0] cap_xd;
    int            idx, dones, stable_err, seen;

    // Single transfer, with an ignored offer (55) while waiting; ack mirrored 3 cycles later
    //          v     d      ack   rdy   req   xd     busy  done
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};

    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;

    // ---------------- reset then idle ----------------
    cdn = 1'b0; in_valid = 1'b0; in_data = '0; ack_tgl_async = 1'b0;
`ifdef CDC_TOGGLE_TX_TIMEOUT_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge ck);
    cdn = 1'b1;
    @(negedge ck);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req", req_tgl, 1'b0);
    chk("rst_xd", xd_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // ---------------- table-driven single transfer ----------------
    for (int i = 0; i < 7; i++) begin
      in_valid      = tbl[i].v;
      in_data       = tbl[i].d;
      ack_tgl_async = tbl[i].ack;
      @(negedge ck);
      chk($sformatf("t%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("t%0d_req", i), req_tgl, tbl[i].req);
      chk($sformatf("t%0d_xd", i), xd_data, tbl[i].xd);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("t%0d_done", i), done, tbl[i].dn);
    end
    in_valid = 1'b0;

    // ---------------- back-to-back with mirrored ack ----------------
    cdn = 1'b0; ack_tgl_async = 1'b0;
    repeat (3) @(negedge ck);
    cdn = 1'b1;
    dly = '0; idx = 0; dones = 0; stable_err = 0;
    prev_req = 1'b0; exp_req = 1'b1; cap_xd = '0;
    in_valid = 1'b1; in_data = words[0];
    for (int c = 0; c < 80 && idx < 3; c++) begin
      @(negedge ck);
      if (done) dones++;
      if (req_tgl != prev_req) begin
        chk($sformatf("b2b%0d_req", idx), req_tgl, exp_req);
        chk($sformatf("b2b%0d_xd", idx), xd_data, words[idx]);
        if (idx > 0) chk($sformatf("b2b%0d_done_before", idx), dones, 1);
        exp_req = ~exp_req;
        dones   = 0;
        cap_xd  = xd_data;
        idx++;
        if (idx < 3) in_data = words[idx];
        else begin
          in_valid = 1'b0;
          in_data  = '0;
        end
      end else if (busy && (xd_data != cap_xd)) begin
        stable_err++;
      end
      prev_req      = req_tgl;
      ack_tgl_async = dly[2];
      dly           = {dly[1:0], req_tgl};
    end
    chk("b2b_captures", idx, 3);
    chk("b2b_xd_stable", stable_err, 0);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge ck);
      if (done) seen = 1;
      ack_tgl_async = dly[2];
      dly           = {dly[1:0], req_tgl};
    end
    chk("b2b_last_done", seen, 1);
    @(negedge ck);
    chk("b2b_ack_level", ack_tgl_async, 1'b1);
    chk("b2b_idle_ready", in_ready, 1'b1);

    // ---------------- reset mid-transfer, ack left at 1 ----------------
    in_valid = 1'b1; in_data = 8'h77;
    @(negedge ck);
    in_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    chk("mid_req", req_tgl, 1'b0);
    chk("mid_xd", xd_data, 8'h77);
    @(negedge ck);
    cdn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_xd", xd_data, 8'h00);
    chk("mid_rst_req", req_tgl, 1'b0);
    @(negedge ck);
    cdn = 1'b1;
    // the freshly cleared chain needs SS edges to pick up the stale ack level
    seen = 0;
    repeat (SS) begin
      @(negedge ck);
      if (done) seen = 1;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge ck);
      if (done) seen = 1;
      chk($sformatf("mis%0d_in_ready", c), in_ready, 1'b0);
    end
    ack_tgl_async = 1'b0;
    repeat (SS) begin
      @(negedge ck);
      if (done) seen = 1;
    end
    chk("mis_recover_ready", in_ready, 1'b1);
    chk("mis_no_done", seen, 0);
    chk("mis_busy", busy, 1'b0);
    chk("mis_req", req_tgl, 1'b0);

`ifdef CDC_TOGGLE_TX_TIMEOUT_EN
    // ---------------- watchdog ----------------
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge ck);
    in_valid = 1'b0;
    chk("to_busy", busy, 1'b1);
    repeat (TO - 1) @(negedge ck);
    chk("to_err_early", err, 1'b0);
    @(negedge ck);
    chk("to_err_set", err, 1'b1);
    repeat (3) @(negedge ck);
    chk("to_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge ck);
    err_clr = 1'b0;
    chk("to_err_clr", err, 1'b0);
    chk("to_still_busy", busy, 1'b1);
    ack_tgl_async = 1'b1;
    repeat (SS) @(negedge ck);
    chk("to_done_not_yet", done, 1'b0);
    @(negedge ck);
    chk("to_late_done", done, 1'b1);
    chk("to_err_stays_clr", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_cdc_toggle_tx
`default_nettype wire

// File: doc/cdc_toggle_tx.md
Name: cdc_toggle_tx

Overview:
Source-domain (sending) end of a two-phase toggle clock-domain-crossing handshake. Captures one data word per transfer and holds it stable on a crossing bus. Flips a request level toward the destination domain. Synchronizes the destination's returned acknowledge toggle and reopens for the next word once the two levels match. The destination end is a plain 2-flop synchronizer on req_tgl plus an edge detector.

Parameters:
DW, 8, width of transferred data word (1..64)
SYNC_STAGES, 2, flops in the ack synchronizer chain (2..4)
TIMEOUT_CYCLES, 1024, watchdog limit in ck cycles (used only with the optional feature; >= 16)

Ports:
ck  input  1  rising-edge clock, source domain
cdn  input  1  asynchronous active-low reset
in_valid  input  1  source offers a word
in_data  input  DW  word to transfer
in_ready  output  1  block can accept a word this cycle
xd_data  output  DW  registered crossing data bus, stable while a transfer is outstanding
req_tgl  output  1  request toggle toward the destination domain (registered)
ack_tgl_async  input  1  ack toggle from the destination domain (asynchronous)
done  output  1  one-cycle pulse when the ack for the current word is seen
busy  output  1  high while a transfer is outstanding

Behaviour:
- Clocking and reset: one clock, ck. Reset is asynchronous and active-low on cdn. Every flop resets to 0: req_tgl, xd_data, the sync chain, state, done.
- States: IDLE, WAIT_ACK. ack_s is the last stage of the SYNC_STAGES-deep chain on ack_tgl_async.
- in_ready = (state==IDLE) && (ack_s==req_tgl). busy = (state==WAIT_ACK). Both are combinational from flops.
- IDLE, when in_valid && in_ready: on the same edge, xd_data <= in_data, req_tgl <= ~req_tgl, and state moves to WAIT_ACK.
  - xd_data and req_tgl update on the same edge. The destination's synchronizer delay covers data settling.
- in_valid while in_ready is low is ignored. No capture, no state change.
- WAIT_ACK, when ack_s==req_tgl: state moves to IDLE and done pulses high for 1 cycle.
  - xd_data holds its value until the next capture.
  - The earliest next capture is the cycle after done.
- Latency: done follows the req edge by (destination sync delay + SYNC_STAGES + 1) ck cycles, measured in the ck domain.
- Mismatch in IDLE (e.g. destination not reset together with this block): in_ready stays low until ack_s==req_tgl. No word is lost and no spurious done is produced.
- Reset mid-transfer: the block returns to IDLE immediately and xd_data clears. Recovery follows the mismatch rule above.
- No queueing: at most one word is in flight.

Optional Feature:
Macro CDC_TOGGLE_TX_TIMEOUT_EN.
- Defined:
  - Adds a counter that clears on entry to WAIT_ACK and increments each WAIT_ACK cycle, saturating.
  - When the count reaches TIMEOUT_CYCLES, sticky output err (1 bit, reset 0) is set.
  - Adds input err_clr (1 bit); err_clr high for one cycle clears err.
  - If err_clr and a new timeout occur in the same cycle, the timeout wins.
  - The transfer is not aborted; the FSM keeps waiting for the ack.
- Undefined: no counter, no err or err_clr ports, zero extra flops.

Decomposition:
- Shared package cdc_pkg:
  - state enum {IDLE, WAIT_ACK}
  - constants CDC_SYNC_MIN=2 and CDC_SYNC_MAX=4, used for parameter range checks
- Sub-module sync_ff_chain (parameter STAGES):
  - async-clear, active-low, 1-bit multi-flop synchronizer
  - used for ack_tgl_async here and reusable by the destination end

Test Plan:
- Reset then idle: cdn low for 3 cycles then high, ack_tgl_async=0 -> in_ready=1, req_tgl=0, xd_data=0, busy=0, done=0.
- Single transfer: in_data=8'hA5 with in_valid for 1 cycle; bench mirrors req back as ack after 3 cycles -> xd_data=A5 and req_tgl=1 on the next edge, done pulses exactly 2+1 cycles after ack toggles, then in_ready=1.
- Back-to-back: in_valid held high with data 01,02,03 -> three captures, req_tgl sequence 1,0,1, each done pulse before the next capture, xd_data stable through each WAIT_ACK.
- Ignored input: assert in_valid with in_data=8'h55 during WAIT_ACK -> xd_data unchanged, no extra toggle.
- Reset mid-transfer: cdn pulsed low during WAIT_ACK with the ack line left at 1 -> state IDLE, req_tgl=0, in_ready=0 until ack_tgl_async returns to 0, no done pulse.
- Timeout (macro defined, TIMEOUT_CYCLES=16): never return ack -> err=1 after 16 WAIT_ACK cycles. err_clr clears it. A late ack still produces done.
